nanop_alu_ctrl_pc: RTL and testbench



---
 rtl/nanop_alu_ctrl_pc.sv | 134 +++++++++++++
 tb/tb_nanop_alu_ctrl_pc.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nanop_alu_ctrl_pc.sv
// Datapath-control trio of the nanoprocessor: program counter, ALU and the
// two-state FETCH/EXEC controller, grouped behind one top module.

module nanop_pc (
  input  logic       clk,
  input  logic       reset_n,
  output logic [7:0] PC
);

  logic [7:0] r_pc;

  // Free-running address counter; wraps naturally at 8 bits
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc <= 8'd0;
    end else begin
      r_pc <= r_pc + 8'd1;
    end
  end

  assign PC = r_pc;

endmodule

module nanop_alu (
  input  logic [7:0] I,
  input  logic [7:0] Op1,
  input  logic [7:0] Op2,
  output logic [7:0] ALU_out
);

  localparam logic [7:0] OP_XOR = 8'h01;
  localparam logic [7:0] OP_AND = 8'h02;
  localparam logic [7:0] OP_OR  = 8'h03;
  localparam logic [7:0] OP_ADD = 8'h04;
  localparam logic [7:0] OP_SUB = 8'h06;

  always_comb begin
    ALU_out = Op1;
    case (I)
      OP_XOR:  ALU_out = Op1 ^ Op2;
      OP_AND:  ALU_out = Op1 & Op2;
      OP_OR:   ALU_out = Op1 | Op2;
      OP_ADD:  ALU_out = Op1 + Op2;
      OP_SUB:  ALU_out = Op1 - Op2;
      default: ALU_out = Op1;
    endcase
  end

endmodule

module nanop_ctrl (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] I,
  output logic       Load_I,
  output logic       Load_Acc,
  output logic       Sel_Acc,
  output logic       WRITE
);

  localparam logic [7:0] OP_XOR = 8'h01;
  localparam logic [7:0] OP_AND = 8'h02;
  localparam logic [7:0] OP_OR  = 8'h03;
  localparam logic [7:0] OP_ADD = 8'h04;
  localparam logic [7:0] OP_SUB = 8'h06;
  localparam logic [7:0] OP_LDA = 8'h0A;
  localparam logic [7:0] OP_STA = 8'h0B;

  typedef enum logic {FETCH = 1'b0, EXEC = 1'b1} state_t;

  state_t r_state;
  logic   w_exec;
  logic   w_accOp;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= FETCH;
    end else begin
      r_state <= (r_state == FETCH) ? EXEC : FETCH;
    end
  end

  // Outputs decode from state and opcode so reset forces them without a clock edge
  always_comb begin
    w_exec  = (r_state == EXEC);
    w_accOp = (I == OP_XOR) || (I == OP_AND) || (I == OP_OR) ||
              (I == OP_ADD) || (I == OP_SUB) || (I == OP_LDA);
    Load_I   = (r_state == FETCH);
    Load_Acc = w_exec && w_accOp;
    Sel_Acc  = w_exec && (I == OP_LDA);
    WRITE    = w_exec && (I == OP_STA);
  end

endmodule

module nanop_alu_ctrl_pc (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] I,
  input  logic [7:0] Op1,
  input  logic [7:0] Op2,
  output logic [7:0] PC,
  output logic [7:0] ALU_out,
  output logic       Load_I,
  output logic       Load_Acc,
  output logic       Sel_Acc,
  output logic       WRITE
);

  nanop_pc u_pc (
    .clk     (clk),
    .reset_n (reset_n),
    .PC      (PC)
  );

  nanop_alu u_alu (
    .I       (I),
    .Op1     (Op1),
    .Op2     (Op2),
    .ALU_out (ALU_out)
  );

  nanop_ctrl u_ctrl (
    .clk      (clk),
    .reset_n  (reset_n),
    .I        (I),
    .Load_I   (Load_I),
    .Load_Acc (Load_Acc),
    .Sel_Acc  (Sel_Acc),
    .WRITE    (WRITE)
  );

endmodule

// File: tb/tb_nanop_alu_ctrl_pc.sv
// Bench for nanop_alu_ctrl_pc: models the external IR, accumulator and RAM,
// and checks the DUT through a scoreboard queue drained by a monitor process.

module tb_nanop_alu_ctrl_pc;

  logic       clk;
  logic       reset_n;
  logic [7:0] I, Op1, Op2;
  logic [7:0] PC, ALU_out;
  logic       Load_I, Load_Acc, Sel_Acc, WRITE;

  logic [7:0] mem [256];
  logic [7:0] din;
  logic [7:0] irReg;
  logic [7:0] accReg;

  logic       aluMode;
  logic [7:0] tI, tOp1, tOp2;

  typedef struct {
    string      name;
    int         kind;
    logic [7:0] exp;
  } chk_t;

  chk_t q[$];
  event sampleNow;
  int   nChecks;
  int   nFails;

  localparam int K_PC = 0, K_LDI = 1, K_LDA = 2, K_SEL = 3, K_WR = 4,
                 K_ACC = 5, K_IR = 6, K_ALU = 7, K_M13 = 8;

  nanop_alu_ctrl_pc dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .I        (I),
    .Op1      (Op1),
    .Op2      (Op2),
    .PC       (PC),
    .ALU_out  (ALU_out),
    .Load_I   (Load_I),
    .Load_Acc (Load_Acc),
    .Sel_Acc  (Sel_Acc),
    .WRITE    (WRITE)
  );

  assign I   = aluMode ? tI   : irReg;
  assign Op1 = aluMode ? tOp1 : accReg;
  assign Op2 = aluMode ? tOp2 : din;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External datapath: IR and accumulator on the rising edge, RAM on the falling edge
  always @(posedge clk) begin
    if (Load_I) irReg <= din;
    if (Load_Acc) accReg <= Sel_Acc ? din : ALU_out;
  end

  always @(negedge clk) begin
    if (WRITE) mem[PC] <= accReg;
    din <= WRITE ? accReg : mem[PC];
  end

  function automatic logic [7:0] getActual(input int kind);
    case (kind)
      K_PC:    return PC;
      K_LDI:   return {7'd0, Load_I};
      K_LDA:   return {7'd0, Load_Acc};
      K_SEL:   return {7'd0, Sel_Acc};
      K_WR:    return {7'd0, WRITE};
      K_ACC:   return accReg;
      K_IR:    return irReg;
      K_ALU:   return ALU_out;
      K_M13:   return mem[13];
      default: return 8'hxx;
    endcase
  endfunction

  initial begin
    chk_t       c;
    logic [7:0] act;
    forever begin
      @(sampleNow);
      while (q.size() > 0) begin
        c   = q.pop_front();
        act = getActual(c.kind);
        nChecks++;
        if (act !== c.exp) begin
          nFails++;
          $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", c.name, act, c.exp);
        end
      end
    end
  end

  task automatic expectVal(input string name, input int kind, input logic [7:0] exp);
    chk_t c;
    c.name = name;
    c.kind = kind;
    c.exp  = exp;
    q.push_back(c);
  endtask

  task automatic sample();
    -> sampleNow;
    #1;
  endtask

  task automatic stepEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic applyAlu(input string name, input logic [7:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] exp);
    tI   = op;
    tOp1 = a;
    tOp2 = b;
    #1;
    expectVal(name, K_ALU, exp);
    sample();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0] accExp [7];
    nChecks = 0;
    nFails  = 0;
    aluMode = 1'b0;
    tI = 8'h00; tOp1 = 8'h00; tOp2 = 8'h00;
    reset_n = 1'b0;
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
    // LDA 3, ADD 4, SUB 1, XOR 3, AND 11, OR 24, STA, unknown 0x0D, OR 0
    mem[0]  = 8'h0A; mem[1]  = 8'h03;
    mem[2]  = 8'h04; mem[3]  = 8'h04;
    mem[4]  = 8'h06; mem[5]  = 8'h01;
    mem[6]  = 8'h01; mem[7]  = 8'h03;
    mem[8]  = 8'h02; mem[9]  = 8'h0B;
    mem[10] = 8'h03; mem[11] = 8'h18;
    mem[12] = 8'h0B; mem[13] = 8'h00;
    mem[14] = 8'h0D; mem[15] = 8'h55;
    mem[16] = 8'h03; mem[17] = 8'h00;
    accExp = '{8'd3, 8'd7, 8'd6, 8'd5, 8'd1, 8'd25, 8'd0};

    #3;
    expectVal("reset PC", K_PC, 8'd0);
    expectVal("reset Load_I", K_LDI, 8'd1);
    expectVal("reset Load_Acc", K_LDA, 8'd0);
    expectVal("reset Sel_Acc", K_SEL, 8'd0);
    expectVal("reset WRITE", K_WR, 8'd0);
    sample();

    @(negedge clk);
    #2 reset_n = 1'b1;

    for (int e = 1; e <= 12; e++) begin
      stepEdge();
      if (e == 1) begin
        expectVal("edge1 IR", K_IR, 8'h0A);
        expectVal("edge1 PC", K_PC, 8'd1);
      end
      if (e % 2 == 0) expectVal($sformatf("edge%0d Acc", e), K_ACC, accExp[e/2 - 1]);
      expectVal($sformatf("edge%0d Load_I", e), K_LDI, (e % 2 == 0) ? 8'd1 : 8'd0);
      sample();
    end

    stepEdge();
    expectVal("STA PC", K_PC, 8'd13);
    expectVal("STA WRITE", K_WR, 8'd1);
    expectVal("STA Load_Acc", K_LDA, 8'd0);
    sample();
    @(negedge clk);
    #1;
    expectVal("STA mem13", K_M13, 8'd25);
    sample();
    stepEdge();
    expectVal("post STA WRITE", K_WR, 8'd0);
    expectVal("post STA PC", K_PC, 8'd14);
    sample();

    stepEdge();
    expectVal("nop IR", K_IR, 8'h0D);
    expectVal("nop Load_Acc", K_LDA, 8'd0);
    expectVal("nop WRITE", K_WR, 8'd0);
    sample();
    stepEdge();
    expectVal("nop Acc", K_ACC, 8'd25);
    expectVal("nop PC", K_PC, 8'd16);
    sample();

    stepEdge();
    expectVal("OR0 Load_Acc", K_LDA, 8'd1);
    expectVal("OR0 Load_I", K_LDI, 8'd0);
    sample();
    #1 reset_n = 1'b0;
    #1;
    expectVal("midrst PC", K_PC, 8'd0);
    expectVal("midrst Load_I", K_LDI, 8'd1);
    expectVal("midrst Load_Acc", K_LDA, 8'd0);
    expectVal("midrst WRITE", K_WR, 8'd0);
    sample();
    @(negedge clk);
    #2 reset_n = 1'b1;
    stepEdge();
    expectVal("restart IR", K_IR, 8'h0A);
    expectVal("restart PC", K_PC, 8'd1);
    sample();
    stepEdge();
    expectVal("restart Acc", K_ACC, 8'd3);
    sample();

    reset_n = 1'b0;
    aluMode = 1'b1;
    applyAlu("ALU ADD wrap", 8'h04, 8'd200, 8'd100, 8'd44);
    applyAlu("ALU SUB wrap", 8'h06, 8'd3, 8'd5, 8'd254);
    applyAlu("ALU AND", 8'h02, 8'hF0, 8'h3C, 8'h30);
    applyAlu("ALU OR", 8'h03, 8'hF0, 8'h3C, 8'hFC);
    applyAlu("ALU XOR", 8'h01, 8'hF0, 8'h3C, 8'hCC);
    applyAlu("ALU unknown", 8'h0D, 8'hF0, 8'h3C, 8'hF0);
    applyAlu("ALU LDA pass", 8'h0A, 8'h5A, 8'h3C, 8'h5A);
    aluMode = 1'b0;

    @(negedge clk);
    #2 reset_n = 1'b1;
    for (int k = 1; k <= 257; k++) begin
      stepEdge();
      expectVal($sformatf("wrap%0d PC", k), K_PC, 8'(k % 256));
      expectVal($sformatf("wrap%0d Load_I", k), K_LDI, (k % 2 == 0) ? 8'd1 : 8'd0);
      sample();
    end

    #2;
    if (q.size() != 0) begin
      nFails++;
      $display("[TB] FAIL scoreboard drain: got %0d pending, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
